// File: rtl/traffic_light_ctrl.sv
// Main/side street traffic light sequencer with pedestrian walk phase.
// Each state selects a duration interval, waits two cycles for the parameter block, then counts ticks.
module traffic_light_ctrl #(
  parameter logic [1:0] BASE_SEL = 2'b00,
  parameter logic [1:0] EXTD_SEL = 2'b01,
  parameter logic [1:0] YELL_SEL = 2'b10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       tick_1hz,
  input  logic       Sensor_Sync,
  input  logic       WR_Sync,
  input  logic       Reprogram,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_MG     = 3'd0,
    S_MG_EXT = 3'd1,
    S_MY     = 3'd2,
    S_WALK   = 3'd3,
    S_SG     = 3'd4,
    S_SG_EXT = 3'd5,
    S_SY     = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t     state_q, state_d;
  logic [1:0] settle_q, settle_d;
  logic [3:0] cnt_q, cnt_d;
  logic       walk_pend_q, walk_pend_d;
  logic [1:0] interval_q, interval_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       expire_s;
  logic       enter_walk_s;
  state_t     succ_s;

  function automatic logic [1:0] state_interval(input state_t s);
    case (s)
      S_MG, S_SG:               state_interval = BASE_SEL;
      S_MG_EXT, S_WALK, S_SG_EXT: state_interval = EXTD_SEL;
      S_MY, S_SY:               state_interval = YELL_SEL;
      default:                  state_interval = BASE_SEL;
    endcase
  endfunction

  function automatic logic [2:0] main_lamps(input state_t s);
    case (s)
      S_MG, S_MG_EXT: main_lamps = LAMP_G;
      S_MY:           main_lamps = LAMP_Y;
      default:        main_lamps = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamps(input state_t s);
    case (s)
      S_SG, S_SG_EXT: side_lamps = LAMP_G;
      S_SY:           side_lamps = LAMP_Y;
      default:        side_lamps = LAMP_R;
    endcase
  endfunction

  // Successor taken at expiry; sensor and walk request are only consulted here.
  always_comb begin
    succ_s = S_MG;
    case (state_q)
      S_MG:     succ_s = Sensor_Sync ? S_MY : S_MG_EXT;
      S_MG_EXT: succ_s = S_MY;
      S_MY:     succ_s = walk_pend_q ? S_WALK : S_SG;
      S_WALK:   succ_s = S_SG;
      S_SG:     succ_s = Sensor_Sync ? S_SG_EXT : S_SY;
      S_SG_EXT: succ_s = S_SY;
      S_SY:     succ_s = S_MG;
      default:  succ_s = S_MG;
    endcase
  end

  // Next-state, load/countdown and registered-output computation.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    expire_s = (settle_q == 2'd0) && tick_1hz && (cnt_q == 4'd1);
    enter_walk_s = 1'b0;
    if (Reprogram || (state_q == S_BAD)) begin
      state_d  = S_MG;
      settle_d = 2'd2;
    end else if (expire_s) begin
      state_d      = succ_s;
      settle_d     = 2'd2;
      enter_walk_s = (succ_s == S_WALK);
    end else if (settle_q != 2'd0) begin
      settle_d = settle_q - 2'd1;
      if (settle_q == 2'd1) begin
        cnt_d = (value == 4'd0) ? 4'd1 : value;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (tick_1hz && (cnt_q > 4'd1)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
    walk_pend_d = enter_walk_s ? 1'b0 : (walk_pend_q | WR_Sync);
    interval_d  = state_interval(state_d);
    main_d      = main_lamps(state_d);
    side_d      = side_lamps(state_d);
    walk_d      = (state_d == S_WALK);
  end

  // State, counters and lamp outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_MG;
      settle_q    <= 2'd2;
      cnt_q       <= 4'd0;
      walk_pend_q <= 1'b0;
      interval_q  <= BASE_SEL;
      main_q      <= LAMP_G;
      side_q      <= LAMP_R;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      walk_pend_q <= walk_pend_d;
      interval_q  <= interval_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_q      <= walk_d;
    end
  end

  assign interval    = interval_q;
  assign main_lights = main_q;
  assign side_lights = side_q;
  assign walk_lamp   = walk_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed self-checking bench for traffic_light_ctrl with a registered time-parameter model.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       Reset, tick_1hz, Sensor_Sync, WR_Sync, Reprogram;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] main_lights, side_lights, state_dbg;
  logic       walk_lamp;

  logic [3:0] base_v, extd_v, yell_v;
  int         tick_ctr;
  logic       per_tick;
  logic       mon_en;
  int         n_checks = 0;
  int         n_fail = 0;

  localparam int MG = 0, MG_EXT = 1, MY = 2, WALK = 3, SG = 4, SG_EXT = 5, SY = 6;

  traffic_light_ctrl dut (
    .clk(clk), .Reset(Reset), .tick_1hz(tick_1hz), .Sensor_Sync(Sensor_Sync),
    .WR_Sync(WR_Sync), .Reprogram(Reprogram), .value(value), .interval(interval),
    .main_lights(main_lights), .side_lights(side_lights), .walk_lamp(walk_lamp),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Time-parameter block: registers the selected duration one cycle after interval changes.
  always @(posedge clk) begin
    case (interval)
      2'b00:   value <= base_v;
      2'b01:   value <= extd_v;
      2'b10:   value <= yell_v;
      default: value <= 4'd0;
    endcase
  end

  // Lamp safety: at least one street shows red every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      assert (main_lights === 3'b100 || side_lights === 3'b100) else begin
        n_fail++;
        $error("FAIL lamp_invariant: main=%b side=%b, required one of them 100", main_lights, side_lights);
      end
    end
  end

  function automatic int exp_int(input int s);
    case (s)
      MG, SG:              return 0;
      MG_EXT, WALK, SG_EXT: return 1;
      default:             return 2;
    endcase
  endfunction

  function automatic int exp_main(input int s);
    case (s)
      MG, MG_EXT: return 1;
      MY:         return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int exp_side(input int s);
    case (s)
      SG, SG_EXT: return 1;
      SY:         return 2;
      default:    return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    WR_Sync   = 1'b0;
    Reprogram = 1'b0;
    tick_ctr  = (tick_ctr == 9) ? 0 : tick_ctr + 1;
    per_tick  = (tick_ctr == 9);
    tick_1hz  = per_tick;
  endtask

  task automatic chk_state(input int st);
    chk($sformatf("S%0d_state", st), {29'd0, state_dbg}, st);
    chk($sformatf("S%0d_interval", st), {30'd0, interval}, exp_int(st));
    chk($sformatf("S%0d_main", st), {29'd0, main_lights}, exp_main(st));
    chk($sformatf("S%0d_side", st), {29'd0, side_lights}, exp_side(st));
    chk($sformatf("S%0d_walk", st), {31'd0, walk_lamp}, (st == WALK) ? 1 : 0);
  endtask

  // Count periodic ticks spent in state st until it changes; optionally inject ticks during load.
  task automatic dwell(input int st, input int exp_ticks, input int nxt, input bit inject);
    int t, k;
    chk_state(st);
    t = 0;
    k = 0;
    while (state_dbg == 3'(st) && k < 10 * exp_ticks + 40) begin
      if (inject && k < 2) tick_1hz = 1'b1;
      if (per_tick) t++;
      cyc();
      k++;
    end
    chk($sformatf("S%0d_dwell_ticks", st), t, exp_ticks);
    chk($sformatf("S%0d_next", st), {29'd0, state_dbg}, nxt);
  endtask

  task automatic chk_reset();
    chk("rst_state", {29'd0, state_dbg}, 0);
    chk("rst_interval", {30'd0, interval}, 0);
    chk("rst_main", {29'd0, main_lights}, 32'h1);
    chk("rst_side", {29'd0, side_lights}, 32'h4);
    chk("rst_walk", {31'd0, walk_lamp}, 0);
  endtask

  initial begin
    int t, k;
    Reset = 1'b1; tick_1hz = 1'b0; Sensor_Sync = 1'b0; WR_Sync = 1'b0; Reprogram = 1'b0;
    base_v = 4'd6; extd_v = 4'd3; yell_v = 4'd2;
    tick_ctr = 0; per_tick = 1'b0; mon_en = 1'b0;
    cyc();
    mon_en = 1'b1;
    cyc();
    cyc();
    chk_reset();
    Reset = 1'b0; tick_ctr = 0; per_tick = 1'b0; tick_1hz = 1'b0;

    // Default cycle, no sensor, no walk.
    dwell(MG, 6, MG_EXT, 1'b0);
    dwell(MG_EXT, 3, MY, 1'b0);
    dwell(MY, 2, SG, 1'b0);
    dwell(SG, 6, SY, 1'b0);
    dwell(SY, 2, MG, 1'b0);

    // Sensor held: extension moves to side street.
    Sensor_Sync = 1'b1;
    dwell(MG, 6, MY, 1'b0);
    dwell(MY, 2, SG, 1'b0);
    dwell(SG, 6, SG_EXT, 1'b0);
    dwell(SG_EXT, 3, SY, 1'b0);
    dwell(SY, 2, MG, 1'b0);
    Sensor_Sync = 1'b0;

    // Walk request in MG, served once.
    WR_Sync = 1'b1;
    dwell(MG, 6, MG_EXT, 1'b0);
    dwell(MG_EXT, 3, MY, 1'b0);
    dwell(MY, 2, WALK, 1'b0);
    dwell(WALK, 3, SG, 1'b0);
    dwell(SG, 6, SY, 1'b0);
    dwell(SY, 2, MG, 1'b0);
    dwell(MG, 6, MG_EXT, 1'b0);
    dwell(MG_EXT, 3, MY, 1'b0);
    dwell(MY, 2, SG, 1'b0);
    dwell(SG, 6, SY, 1'b0);

    // Zero duration becomes one tick; ticks during load are ignored.
    yell_v = 4'd0;
    dwell(SY, 1, MG, 1'b1);
    yell_v = 4'd2;
    dwell(MG, 6, MG_EXT, 1'b1);
    dwell(MG_EXT, 3, MY, 1'b0);
    dwell(MY, 2, SG, 1'b0);

    // Reprogram in SG with two ticks consumed; pending walk survives.
    chk_state(SG);
    t = 0;
    k = 0;
    while (t < 2 && k < 40) begin
      if (per_tick) t++;
      cyc();
      k++;
    end
    chk("sg_two_ticks", t, 2);
    WR_Sync = 1'b1;
    cyc();
    Reprogram = 1'b1;
    base_v = 4'd9;
    cyc();
    chk_state(MG);
    dwell(MG, 9, MG_EXT, 1'b0);
    dwell(MG_EXT, 3, MY, 1'b0);
    dwell(MY, 2, WALK, 1'b0);
    dwell(WALK, 3, SG, 1'b0);

    // Reset in the middle of SG_EXT.
    Sensor_Sync = 1'b1;
    dwell(SG, 9, SG_EXT, 1'b0);
    for (int i = 0; i < 12; i++) cyc();
    chk("pre_reset_sg_ext", {29'd0, state_dbg}, SG_EXT);
    Reset = 1'b1;
    cyc();
    chk_reset();
    Reset = 1'b0; Sensor_Sync = 1'b0; tick_ctr = 0; per_tick = 1'b0; tick_1hz = 1'b0;
    dwell(MG, 9, MG_EXT, 1'b0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Main-street/side-street traffic light sequencer that drives the time-parameter block. Each state selects an interval (base, extended or yellow) on `interval` and reads back the programmed 4-bit `value`. It then counts that many one-second ticks before advancing. It also handles the side-street car sensor, a latched pedestrian walk request, and restarts when parameters are reprogrammed.

Parameters:
- BASE_SEL, 2'b00, interval code for base duration
- EXTD_SEL, 2'b01, interval code for extended duration
- YELL_SEL, 2'b10, interval code for yellow duration

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle enable per second
- Sensor_Sync  in  1  side-street car present (synchronised level)
- WR_Sync  in  1  walk request (synchronised, one-cycle pulse)
- Reprogram  in  1  pulse: time parameters changed; restart sequence
- value  in  4  duration from time-parameter block, in seconds
- interval  out  2  interval select to time-parameter block
- main_lights  out  3  {R,Y,G} main street
- side_lights  out  3  {R,Y,G} side street
- walk_lamp  out  1  pedestrian walk indicator
- state_dbg  out  3  current state encoding

Behaviour:
- States and their encodings, intervals and lamps (main/side/walk):
  - MG=0: BASE; main G, side R
  - MG_EXT=1: EXTD; main G, side R
  - MY=2: YELL; main Y, side R
  - WALK=3: EXTD; main R, side R, walk_lamp=1
  - SG=4: BASE; main R, side G
  - SG_EXT=5: EXTD; main R, side G
  - SY=6: YELL; main R, side Y
- Encoding 7 is illegal and recovers to MG on the next edge.
- All outputs are registered and change on the edge that enters a state.
- Transitions at expiry:
  - MG → MY if Sensor_Sync=1, else MG_EXT
  - MG_EXT → MY
  - MY → WALK if walk_pending=1, else SG
  - WALK → SG
  - SG → SG_EXT if Sensor_Sync=1, else SY
  - SG_EXT → SY
  - SY → MG
- Sensor_Sync is sampled only on the expiry cycle.
- Load phase:
  - The time-parameter block registers `value` one cycle after `interval` changes.
  - On state entry, a settle counter is set to 2 and decrements every clk.
  - On the edge where settle goes 1→0, cnt <= value. If value==0, cnt <= 1.
  - tick_1hz is ignored during the load phase.
- Countdown:
  - After load, each tick_1hz with cnt>1 decrements cnt.
  - A tick_1hz with cnt==1 is expiry: the next state is entered on that edge.
  - Dwell is exactly `value` ticks, with the first tick counted only after the load completes.
- Walk:
  - A WR_Sync pulse sets walk_pending in any state.
  - walk_pending clears on the edge entering WALK.
  - A WR_Sync arriving in that same cycle is dropped.
- Reprogram:
  - Forces entry to MG (fresh load phase) on the next edge, from any state.
  - walk_pending is preserved.
  - Reprogram takes priority over expiry.
- Reset:
  - Takes priority over everything; applies mid-countdown or mid-load.
  - Reset state: MG, interval=BASE_SEL, main_lights=3'b001, side_lights=3'b100, walk_lamp=0, walk_pending=0, settle=2, cnt=0, state_dbg=0.
  - After Reset deasserts, the load phase runs normally.
- Lamp safety invariant: main and side are never both non-red in any cycle.
- Width rules: cnt is 4 bits and never wraps. cnt==0 occurs only before the first load.

Test Plan:
- Default parameters (base 6, extd 3, yellow 2), Sensor=0, no WR, tick every 10 clks → MG 6 ticks, MG_EXT 3, MY 2, SG 6, SY 2, back to MG; interval sequence 00,01,10,00,10,00.
- Sensor_Sync=1 held → MG 6 → MY 2 → SG 6 → SG_EXT 3 → SY 2; MG_EXT never visited.
- WR_Sync pulse during MG → after MY, WALK lasts 3 ticks with walk_lamp=1 and both streets red; the next cycle through MY skips WALK.
- value=0 returned during SY → SY lasts 1 tick. tick_1hz asserted during the two load cycles → ignored; dwell unchanged.
- Reprogram pulse in SG with cnt=4 → next edge state_dbg=0, interval=00; new base value (e.g. 9) loaded 2 cycles later, MG lasts 9 ticks.
- Reset asserted mid-SG_EXT → next edge matches the reset state; check the lamp invariant every cycle throughout all tests.
